// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
//   Sequencer for the shared 8x8 combinational array multiplier. It latches a
//   MUL request and holds the operands on the multiplier inputs. It waits
//   MUL_CYCLES cycles for the array to settle, then captures the product. The
//   product is written back as two 8-bit register-file writes, low byte first
//   and then high byte, on a write port shared with the ALU. busy stalls the
//   pipeline for the whole operation.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   MUL request, sampled only in IDLE
//   op_a/op_b in   operands, sampled with start
//   rd_lo/hi  in   destination registers for product low/high byte
//   mul_a/b   out  registered operands to the multiplier array
//   mul_prod  in   combinational multiplier result
//   wb_en     out  register-file write request
//   wb_addr   out  write address
//   wb_data   out  write data
//   wb_gnt    in   write port granted this cycle
//   busy      out  operation in progress (pipeline stall)
//   done      out  one-cycle completion pulse, first IDLE cycle
//   prod      out  captured product
//   z_flag    out  prod == 0, updated at capture
module mul_seq_ctrl #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            op_a,
  input  logic [7:0]            op_b,
  input  logic [REG_ADDR_W-1:0] rd_lo,
  input  logic [REG_ADDR_W-1:0] rd_hi,
  output logic [7:0]            mul_a,
  output logic [7:0]            mul_b,
  input  logic [15:0]           mul_prod,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [7:0]            wb_data,
  input  logic                  wb_gnt,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           prod,
  output logic                  z_flag
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WB_LO = 2'd2,
    S_WB_HI = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic [7:0]              r_mul_a;
  logic [7:0]              r_mul_b;
  logic [REG_ADDR_W-1:0]   r_rd_lo;
  logic [REG_ADDR_W-1:0]   r_rd_hi;
  logic [15:0]             r_prod;
  logic                    r_z;
  logic                    r_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == 4'd0) w_next = S_WB_LO;
      S_WB_LO: if (wb_gnt) w_next = S_WB_HI;
      S_WB_HI: if (wb_gnt) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_rd_lo <= '0;
      r_rd_hi <= '0;
      r_prod  <= '0;
      r_z     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mul_a <= op_a;
            r_mul_b <= op_b;
            r_rd_lo <= rd_lo;
            r_rd_hi <= rd_hi;
            r_cnt   <= 4'(MUL_CYCLES - 1);
          end
        end
        S_CALC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_prod <= mul_prod;
            r_z    <= (mul_prod == 16'd0);
          end
        end
        S_WB_HI: begin
          if (wb_gnt) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write-port outputs depend on r_state only, so wb_gnt never reaches them
  // combinationally; a refused write simply keeps the same state.
  always_comb begin
    busy    = 1'b0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    case (r_state)
      S_CALC: busy = 1'b1;
      S_WB_LO: begin
        busy    = 1'b1;
        wb_en   = 1'b1;
        wb_addr = r_rd_lo;
        wb_data = r_prod[7:0];
      end
      S_WB_HI: begin
        busy    = 1'b1;
        wb_en   = 1'b1;
        wb_addr = r_rd_hi;
        wb_data = r_prod[15:8];
      end
      default: ;
    endcase
  end

  assign mul_a  = r_mul_a;
  assign mul_b  = r_mul_b;
  assign prod   = r_prod;
  assign z_flag = r_z;
  assign done   = r_done;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  // DUT with the default settle time of 2 cycles
  logic        start;
  logic [7:0]  op_a, op_b;
  logic [2:0]  rd_lo, rd_hi;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_prod;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        wb_gnt;
  logic        busy, done, z_flag;
  logic [15:0] prod;

  // DUT with a settle time of 1 cycle
  logic        start1;
  logic [7:0]  op_a1, op_b1;
  logic [7:0]  mul_a1, mul_b1;
  logic [15:0] mul_prod1;
  logic        wb_en1;
  logic [2:0]  wb_addr1;
  logic [7:0]  wb_data1;
  logic        busy1, done1, z_flag1;
  logic [15:0] prod1;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  // Models of the external combinational array multipliers
  assign mul_prod  = 16'(mul_a)  * 16'(mul_b);
  assign mul_prod1 = 16'(mul_a1) * 16'(mul_b1);

  mul_seq_ctrl #(.MUL_CYCLES(2), .REG_ADDR_W(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .rd_lo(rd_lo), .rd_hi(rd_hi), .mul_a(mul_a), .mul_b(mul_b),
    .mul_prod(mul_prod), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_gnt(wb_gnt), .busy(busy), .done(done), .prod(prod), .z_flag(z_flag)
  );

  mul_seq_ctrl #(.MUL_CYCLES(1), .REG_ADDR_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1),
    .rd_lo(3'd6), .rd_hi(3'd7), .mul_a(mul_a1), .mul_b(mul_b1),
    .mul_prod(mul_prod1), .wb_en(wb_en1), .wb_addr(wb_addr1), .wb_data(wb_data1),
    .wb_gnt(1'b1), .busy(busy1), .done(done1), .prod(prod1), .z_flag(z_flag1)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One operation on the 2-cycle DUT with wb_gnt held at 1.
  // Start sampled at edge 0: lo write cycle 3, hi write cycle 4, done cycle 5.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] lo, input logic [2:0] hi,
                        input logic [15:0] ep, input logic ez);
    start = 1'b1; op_a = a; op_b = b; rd_lo = lo; rd_hi = hi; wb_gnt = 1'b1;
    tick();
    start = 1'b0;
    chk("c1_busy",  busy,  1'b1);
    chk("c1_wb_en", wb_en, 1'b0);
    chk("c1_mul_a", mul_a, a);
    chk("c1_mul_b", mul_b, b);
    tick();
    chk("c2_busy",  busy,  1'b1);
    chk("c2_wb_en", wb_en, 1'b0);
    tick();
    chk("lo_wb_en", wb_en,   1'b1);
    chk("lo_addr",  wb_addr, lo);
    chk("lo_data",  wb_data, ep[7:0]);
    chk("lo_prod",  prod,    ep);
    chk("lo_z",     z_flag,  ez);
    chk("lo_done",  done,    1'b0);
    tick();
    chk("hi_wb_en", wb_en,   1'b1);
    chk("hi_addr",  wb_addr, hi);
    chk("hi_data",  wb_data, ep[15:8]);
    chk("hi_busy",  busy,    1'b1);
    tick();
    chk("done_pulse", done,  1'b1);
    chk("done_busy",  busy,  1'b0);
    chk("done_wb_en", wb_en, 1'b0);
    tick();
    chk("done_clear", done,  1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; rd_lo = '0; rd_hi = '0;
    wb_gnt = 1'b1; start1 = 1'b0; op_a1 = '0; op_b1 = '0;
    tick();
    tick();
    chk("rst_busy",  busy,    1'b0);
    chk("rst_wb_en", wb_en,   1'b0);
    chk("rst_addr",  wb_addr, 3'd0);
    chk("rst_data",  wb_data, 8'h00);
    chk("rst_done",  done,    1'b0);
    chk("rst_prod",  prod,    16'h0000);
    chk("rst_z",     z_flag,  1'b0);
    chk("rst_mul_a", mul_a,   8'h00);
    chk("rst_busy1", busy1,   1'b0);
    rst = 1'b0;
    tick();

    // Basic operation and corner products
    run_op(8'h0F, 8'h11, 3'd1, 3'd2, 16'h00FF, 1'b0);
    run_op(8'hFF, 8'hFF, 3'd3, 3'd4, 16'hFE01, 1'b0);
    run_op(8'h00, 8'h5A, 3'd1, 3'd2, 16'h0000, 1'b1);
    run_op(8'hFF, 8'hFF, 3'd5, 3'd5, 16'hFE01, 1'b0);

    // Write port withheld for 3 cycles in WB_LO: 0x12*0x34 = 0x03A8
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; rd_lo = 3'd6; rd_hi = 3'd7; wb_gnt = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_wb_en", wb_en,   1'b1);
      chk("stall_addr",  wb_addr, 3'd6);
      chk("stall_data",  wb_data, 8'hA8);
      chk("stall_busy",  busy,    1'b1);
      tick();
    end
    wb_gnt = 1'b1;
    chk("gnt_lo_addr", wb_addr, 3'd6);
    chk("gnt_lo_data", wb_data, 8'hA8);
    tick();
    chk("stall_hi_addr", wb_addr, 3'd7);
    chk("stall_hi_data", wb_data, 8'h03);
    chk("stall_hi_done", done,    1'b0);
    tick();
    chk("stall_done", done, 1'b1);
    chk("stall_prod", prod, 16'h03A8);
    tick();

    // start while busy is ignored: 0x05*0x07 = 0x0023
    start = 1'b1; op_a = 8'h05; op_b = 8'h07; rd_lo = 3'd3; rd_hi = 3'd4;
    tick();
    op_a = 8'h33; op_b = 8'h44; rd_lo = 3'd0; rd_hi = 3'd1;
    tick();
    chk("ign_mul_a", mul_a, 8'h05);
    chk("ign_mul_b", mul_b, 8'h07);
    tick();
    start = 1'b0;
    chk("ign_lo_addr", wb_addr, 3'd3);
    chk("ign_lo_data", wb_data, 8'h23);
    tick();
    chk("ign_hi_addr", wb_addr, 3'd4);
    chk("ign_hi_data", wb_data, 8'h00);
    tick();
    chk("ign_done",  done,  1'b1);
    chk("ign_prod",  prod,  16'h0023);
    chk("ign_mul_a2", mul_a, 8'h05);
    tick();

    // Reset in CALC
    start = 1'b1; op_a = 8'h0F; op_b = 8'h11; rd_lo = 3'd1; rd_hi = 3'd2;
    tick();
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rc_busy",  busy,  1'b0);
    chk("rc_wb_en", wb_en, 1'b0);
    chk("rc_prod",  prod,  16'h0000);
    chk("rc_mul_a", mul_a, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rc_no_done",  done,  1'b0);
      chk("rc_no_wb_en", wb_en, 1'b0);
    end

    // Reset in WB_LO (prod already captured, then cleared)
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rl_pre_wb_en", wb_en, 1'b1);
    chk("rl_pre_prod",  prod,  16'h00FF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rl_busy",  busy,  1'b0);
    chk("rl_wb_en", wb_en, 1'b0);
    chk("rl_prod",  prod,  16'h0000);
    chk("rl_done",  done,  1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rl_no_done",  done,  1'b0);
      chk("rl_no_wb_en", wb_en, 1'b0);
    end
    run_op(8'h0F, 8'h11, 3'd1, 3'd2, 16'h00FF, 1'b0);

    // MUL_CYCLES=1 build, back-to-back: 0x0A*0x0B = 0x006E, then 0xC8*0x03 = 0x0258.
    // Start sampled at edge 0: lo cycle 2, hi cycle 3, done cycle 4.
    start1 = 1'b1; op_a1 = 8'h0A; op_b1 = 8'h0B;
    tick();
    start1 = 1'b0;
    chk("b1_busy", busy1, 1'b1);
    tick();
    chk("b1_lo_en",   wb_en1,   1'b1);
    chk("b1_lo_addr", wb_addr1, 3'd6);
    chk("b1_lo_data", wb_data1, 8'h6E);
    tick();
    chk("b1_hi_addr", wb_addr1, 3'd7);
    chk("b1_hi_data", wb_data1, 8'h00);
    tick();
    chk("b1_done", done1, 1'b1);
    chk("b1_prod", prod1, 16'h006E);
    // start asserted during the done cycle is taken at the next edge
    start1 = 1'b1; op_a1 = 8'hC8; op_b1 = 8'h03;
    tick();
    start1 = 1'b0;
    chk("b2_done_clr", done1,  1'b0);
    chk("b2_busy",     busy1,  1'b1);
    chk("b2_wb_en",    wb_en1, 1'b0);
    chk("b2_mul_a",    mul_a1, 8'hC8);
    tick();
    chk("b2_lo_en",   wb_en1,   1'b1);
    chk("b2_lo_addr", wb_addr1, 3'd6);
    chk("b2_lo_data", wb_data1, 8'h58);
    chk("b2_prod",    prod1,    16'h0258);
    chk("b2_z",       z_flag1,  1'b0);
    tick();
    chk("b2_hi_data", wb_data1, 8'h02);
    tick();
    chk("b2_done", done1, 1'b1);
    tick();
    chk("b2_done_end", done1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
